// File: rtl/robo_coletor_param_pkg.sv
// Shared definitions for the collector-robot controller.
// Holds the 3-bit state codes, the asserted level for the sensor inputs,
// and the wall-following navigation rule. The top level and the bench
// both import this package.
package robo_coletor_param_pkg;

    // Asserted level of every sensor input.
    localparam logic ACTIVE = 1'b1;

    // State codes as they appear on state_out. Code 3'd7 is unused and
    // treated as illegal.
    typedef enum logic [2:0] {
        STAND_BY        = 3'd0,
        SEARCH_THE_WALL = 3'd1,
        FOLLOW_THE_WALL = 3'd2,
        TURN_90         = 3'd3,
        COLLECT_TRASH   = 3'd4,
        BIN_FULL        = 3'd5,
        TRAPPED         = 3'd6
    } state_e;

    // Navigation rule used by the three moving states. The first match wins.
    // The caller decides separately whether a TURN_90 result becomes TRAPPED.
    function automatic state_e nav_next(
        input logic under,
        input logic barrier,
        input logic bin_is_full,
        input logic head,
        input logic left
    );
        state_e nxt;
        if (under == ACTIVE) begin
            nxt = STAND_BY;
        end else if ((barrier == ACTIVE) && !bin_is_full) begin
            nxt = COLLECT_TRASH;
        end else if (barrier == ACTIVE) begin
            nxt = BIN_FULL;
        end else if (head == ACTIVE) begin
            nxt = TURN_90;
        end else if (left == ACTIVE) begin
            nxt = FOLLOW_THE_WALL;
        end else begin
            nxt = SEARCH_THE_WALL;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/robo_coletor_param_if.sv
// Sensor/actuator bundle between the robot and the controller.
//   slave  : controller side. Sensors are inputs; motor, arm, status and
//            debug signals are outputs.
//   master : robot/bench side. This is the mirror image of slave.
// CNT_W must match the CNT_W of the controller that uses the bundle.
interface robo_coletor_param_if #(
    parameter int CNT_W = 4
);
    logic             head;
    logic             left;
    logic             barrier;
    logic             under;
    logic             empty_bin;
    logic             advance;
    logic             turn;
    logic             collect;
    logic             bin_full;
    logic             trapped;
    logic [CNT_W-1:0] trash_count;
    logic [2:0]       state_out;

    modport master (
        output head, left, barrier, under, empty_bin,
        input  advance, turn, collect, bin_full, trapped, trash_count, state_out
    );

    modport slave (
        input  head, left, barrier, under, empty_bin,
        output advance, turn, collect, bin_full, trapped, trash_count, state_out
    );
endinterface

// File: rtl/robo_coletor_param_contador.sv
// robo_contador: a parametrised up-counter.
// Ports:
//   clock, reset : rising-edge clock and asynchronous active-high reset.
//   clr          : synchronous clear. It takes priority over en.
//   en           : count up by one.
//   count        : current value.
//   terminal     : high while count equals TERMINAL.
module robo_contador #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a clear wins over an increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == TERMINAL);
endmodule

// File: rtl/robo_coletor_param.sv
// Collector-robot controller.
// It runs a wall-following FSM and holds a timed collect phase for each
// item. It also keeps a bin-occupancy count with a full/empty handshake,
// and detects when the robot has been turning in place too long.
// Ports:
//   clock, reset : rising-edge clock and asynchronous active-high reset.
//   bus (slave)  : sensors head/left/barrier/under/empty_bin in;
//                  advance/turn/collect/bin_full/trapped/trash_count/state_out out.
// Every output comes straight from a flop, so there is no combinational
// path from an input to an output.
module robo_coletor_param
    import robo_coletor_param_pkg::*;
#(
    parameter int COLLECT_CYCLES = 4,
    parameter int TURN_LIMIT     = 8,
    parameter int BIN_CAPACITY   = 15,
    parameter int CNT_W          = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    robo_coletor_param_if.slave  bus
);
    localparam int               COL_W = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
    localparam int               TRN_W = $clog2(TURN_LIMIT);
    localparam logic [CNT_W-1:0] CAP   = CNT_W'(BIN_CAPACITY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] trash_count_q, trash_count_d;
    logic             advance_q, advance_d;
    logic             turn_q, turn_d;
    logic             collect_q, collect_d;
    logic             bin_full_q, bin_full_d;
    logic             trapped_q, trapped_d;

    logic             col_clr_s, col_en_s, col_term_s;
    logic             trn_clr_s, trn_en_s, trn_term_s;
    logic [COL_W-1:0] col_count_s;
    logic [TRN_W-1:0] trn_count_s;
    state_e           nav_s;

    // Collect timer. Its terminal value marks the last cycle of collecting.
    robo_contador #(
        .WIDTH    (COL_W),
        .TERMINAL (COL_W'(COLLECT_CYCLES - 1))
    ) u_collect_timer (
        .clock    (clock),
        .reset    (reset),
        .clr      (col_clr_s),
        .en       (col_en_s),
        .count    (col_count_s),
        .terminal (col_term_s)
    );

    // Turn timer. It counts TURN_90 cycles spent with a wall still ahead.
    robo_contador #(
        .WIDTH    (TRN_W),
        .TERMINAL (TRN_W'(TURN_LIMIT - 1))
    ) u_turn_timer (
        .clock    (clock),
        .reset    (reset),
        .clr      (trn_clr_s),
        .en       (trn_en_s),
        .count    (trn_count_s),
        .terminal (trn_term_s)
    );

    // Next-state logic.
    always_comb begin
        state_d = STAND_BY;
        nav_s   = nav_next(bus.under, bus.barrier, (trash_count_q >= CAP),
                           bus.head, bus.left);
        case (state_q)
            STAND_BY:        state_d = (bus.under == ACTIVE) ? STAND_BY : SEARCH_THE_WALL;
            SEARCH_THE_WALL: state_d = nav_s;
            FOLLOW_THE_WALL: state_d = nav_s;
            TURN_90: begin
                // Only a plain "keep turning" outcome can escalate to TRAPPED.
                // Any higher-priority rule wins over it.
                if ((nav_s == TURN_90) && trn_term_s) begin
                    state_d = TRAPPED;
                end else begin
                    state_d = nav_s;
                end
            end
            COLLECT_TRASH: begin
                if (bus.under == ACTIVE) begin
                    state_d = STAND_BY;
                end else if (col_term_s) begin
                    state_d = SEARCH_THE_WALL;
                end else begin
                    state_d = COLLECT_TRASH;
                end
            end
            BIN_FULL:        state_d = (bus.empty_bin == ACTIVE) ? STAND_BY : BIN_FULL;
            TRAPPED:         state_d = (bus.under == ACTIVE) ? STAND_BY : TRAPPED;
            default:         state_d = STAND_BY;
        endcase
    end

    // Timer controls. A timer clears whenever the FSM is not staying in
    // its state. That covers every exit, and also keeps the timer at zero
    // before the next entry.
    always_comb begin
        col_clr_s = (state_d != COLLECT_TRASH);
        col_en_s  = (state_q == COLLECT_TRASH);
        trn_clr_s = (state_d != TURN_90);
        trn_en_s  = (state_q == TURN_90) && (bus.head == ACTIVE);
    end

    // Bin occupancy.
    // A finished collect adds one item; an abort adds nothing.
    // empty_bin is ignored while collecting. In every other state,
    // including BIN_FULL, it empties the bin.
    always_comb begin
        trash_count_d = trash_count_q;
        if (state_q == COLLECT_TRASH) begin
            if ((bus.under != ACTIVE) && col_term_s && (trash_count_q < CAP)) begin
                trash_count_d = trash_count_q + CNT_W'(1);
            end else begin
                trash_count_d = trash_count_q;
            end
        end else if (bus.empty_bin == ACTIVE) begin
            trash_count_d = '0;
        end else begin
            trash_count_d = trash_count_q;
        end
    end

    // Moore output decode. It is taken from the next state, so the
    // registered outputs line up with the state register.
    always_comb begin
        advance_d  = 1'b0;
        turn_d     = 1'b0;
        collect_d  = 1'b0;
        bin_full_d = 1'b0;
        trapped_d  = 1'b0;
        case (state_d)
            SEARCH_THE_WALL: advance_d  = 1'b1;
            FOLLOW_THE_WALL: advance_d  = 1'b1;
            TURN_90:         turn_d     = 1'b1;
            COLLECT_TRASH:   collect_d  = 1'b1;
            BIN_FULL:        bin_full_d = 1'b1;
            TRAPPED:         trapped_d  = 1'b1;
            default:         advance_d  = 1'b0;
        endcase
    end

    // State, bin count and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= STAND_BY;
            trash_count_q <= '0;
            advance_q     <= 1'b0;
            turn_q        <= 1'b0;
            collect_q     <= 1'b0;
            bin_full_q    <= 1'b0;
            trapped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            trash_count_q <= trash_count_d;
            advance_q     <= advance_d;
            turn_q        <= turn_d;
            collect_q     <= collect_d;
            bin_full_q    <= bin_full_d;
            trapped_q     <= trapped_d;
        end
    end

    assign bus.advance     = advance_q;
    assign bus.turn        = turn_q;
    assign bus.collect     = collect_q;
    assign bus.bin_full    = bin_full_q;
    assign bus.trapped     = trapped_q;
    assign bus.trash_count = trash_count_q;
    assign bus.state_out   = state_q;

    // The timer values are observed only through their terminal flags.
    logic unused_s;
    assign unused_s = ^{col_count_s, trn_count_s};
endmodule
